// File: rtl/ram_stream_reader.sv
// Burst reader: streams len words from a 1-cycle-latency RAM through a 2-entry skid buffer.
// Optional abort input is compiled in when RAM_READER_ABORT_EN is defined.
module ram_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] baseAdr,
    input  logic [DEPTH_LOG:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 rdEn,
    output logic [DEPTH_LOG-1:0] rdAdr,
    input  logic [WIDTH-1:0]     rdDat,
    output logic                 outValid,
    output logic [WIDTH-1:0]     outData,
    output logic                 outLast,
    input  logic                 outReady
`ifdef RAM_READER_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [DEPTH_LOG:0]   LEN_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG-1:0] ADR_ONE = {{(DEPTH_LOG-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [DEPTH_LOG:0]   remaining_q, remaining_d;
    logic [DEPTH_LOG-1:0] adr_q, adr_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_last_q, inflight_last_d;
    logic [WIDTH-1:0]     buf_data_q [2];
    logic [WIDTH-1:0]     buf_data_d [2];
    logic [1:0]           buf_last_q, buf_last_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 zero_done_q, zero_done_d;

    logic                 abort_i;
    logic                 pop;
    logic                 last_pop;
    logic                 accept;
    logic [2:0]           occ_sum;
    logic [2:0]           occ_limit;

`ifdef RAM_READER_ABORT_EN
    assign abort_i = abort & (state_q != IDLE);
`else
    assign abort_i = 1'b0;
`endif

    assign accept    = (state_q == IDLE) & start;
    assign occ_sum   = {1'b0, count_q} + {2'b00, inflight_q};
    assign occ_limit = 3'd2 + {2'b00, pop};

    // NOTE: state flops update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && len != '0) state_d = READ;
            READ:    if (abort_i) state_d = IDLE;
                     else if (rdEn && remaining_q == LEN_ONE) state_d = DRAIN;
            DRAIN:   if (abort_i || last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outValid = (count_q != 2'd0);
        outData  = buf_data_q[rd_ptr_q];
        outLast  = buf_last_q[rd_ptr_q] & outValid & ~abort_i;
        pop      = outValid & outReady;
        last_pop = pop & outLast & (state_q == DRAIN);
        busy     = (state_q != IDLE);
        done     = zero_done_q | last_pop | abort_i;
        rdAdr    = adr_q;
        // A read is allowed only if its word is guaranteed a buffer slot on arrival.
        rdEn     = (state_q == READ) & ~abort_i & (remaining_q != '0) & (occ_sum < occ_limit);
    end

    always_comb begin
        remaining_d     = remaining_q;
        adr_d           = adr_q;
        buf_data_d      = buf_data_q;
        buf_last_d      = buf_last_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        inflight_d      = rdEn;
        inflight_last_d = rdEn & (remaining_q == LEN_ONE);
        zero_done_d     = accept & (len == '0);
        count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};

        if (accept && len != '0) begin
            remaining_d = len;
            adr_d       = baseAdr;
        end else if (rdEn) begin
            remaining_d = remaining_q - LEN_ONE;
            adr_d       = adr_q + ADR_ONE;
        end

        if (inflight_q) begin
            buf_data_d[wr_ptr_q] = rdDat;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;

        if (abort_i) begin
            remaining_d = '0;
            inflight_d  = 1'b0;
            count_d     = 2'd0;
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q     <= '0;
            adr_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            // NOTE: the buffer is reset because its head drives outData, which must read 0 in reset.
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            zero_done_q     <= 1'b0;
        end else begin
            remaining_q     <= remaining_d;
            adr_q           <= adr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            zero_done_q     <= zero_done_d;
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model, expected-word queues, directed and random bursts.
// The abort scenario is built only when RAM_READER_ABORT_EN is defined.
module tb_ram_stream_reader;

    localparam int WIDTH     = 32;
    localparam int DEPTH_LOG = 10;
    localparam int DEPTH     = 1 << DEPTH_LOG;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [DEPTH_LOG-1:0] baseAdr;
    logic [DEPTH_LOG:0]   len;
    logic                 busy, done, rdEn, outValid, outLast, outReady;
    logic [DEPTH_LOG-1:0] rdAdr;
    logic [WIDTH-1:0]     rdDat, outData;
`ifdef RAM_READER_ABORT_EN
    logic                 abort;
`endif

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) dut (
        .clk(clk), .rst(rst), .start(start), .baseAdr(baseAdr), .len(len),
        .busy(busy), .done(done), .rdEn(rdEn), .rdAdr(rdAdr), .rdDat(rdDat),
        .outValid(outValid), .outData(outData), .outLast(outLast), .outReady(outReady)
`ifdef RAM_READER_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) if (rdEn) rdDat <= mem[rdAdr];

    int n_cmp = 0;
    int n_err = 0;

    logic [DEPTH_LOG-1:0] exp_adr_q [$];
    logic [WIDTH-1:0]     exp_data_q [$];
    logic                 exp_last_q [$];

    int issued, popped, done_cnt, last_seen, first_rd, last_rd;
    int cyc = 0, valid_total = 0, rd_total = 0;
    logic stall_prev = 1'b0, done_prev = 1'b0, prev_last;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, compares each read address and popped word with the model.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            cyc++;
            if (outValid) valid_total++;
            if (stall_prev && outValid) begin
                check("stall_data", outData, prev_data);
                check("stall_last", outLast, prev_last);
            end
            if (outValid && outReady) begin
                if (exp_data_q.size() == 0) check("word_unexpected", 1, 0);
                else begin
                    check("word_data", outData, exp_data_q.pop_front());
                    check("word_last", outLast, exp_last_q.pop_front());
                end
                popped++;
                if (outLast) last_seen++;
            end
            if (rdEn) begin
                rd_total++;
                if (exp_adr_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_adr", rdAdr, exp_adr_q.pop_front());
                issued++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                check("outstanding_le3", (issued - popped) <= 3, 1);
            end
            if (done_prev) check("busy_after_done", busy, 0);
            if (done) done_cnt++;
            done_prev  = done;
            stall_prev = outValid && !outReady;
            prev_data  = outData;
            prev_last  = outLast;
        end
    end

    task automatic clear_model();
        exp_adr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        issued = 0; popped = 0; done_cnt = 0; last_seen = 0; first_rd = -1; last_rd = -1;
    endtask

    task automatic expect_burst(input logic [DEPTH_LOG-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [DEPTH_LOG-1:0] a;
            a = DEPTH_LOG'(int'(base) + i);
            exp_adr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
            exp_last_q.push_back(i == n - 1);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdEn"}, rdEn, 0);
        check({tag, "_rdAdr"}, rdAdr, 0);
        check({tag, "_outValid"}, outValid, 0);
        check({tag, "_outData"}, outData, 0);
        check({tag, "_outLast"}, outLast, 0);
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_burst(input logic [DEPTH_LOG-1:0] base, input int n, input int mode, input bit poke);
        int k;
        clear_model();
        expect_burst(base, n);
        @(posedge clk); #1;
        baseAdr = base; len = (DEPTH_LOG+1)'(n); start = 1'b1; outReady = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (done_cnt == 0 && k < 4 * n + 20) begin
            outReady = ready_for(mode, k);
            if (poke && k == 3) begin
                start = 1'b1; baseAdr = 10'h200; len = 11'd5;
            end else start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        check("done_seen", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("word_count", popped, n);
        check("done_pulses", done_cnt, 1);
        check("last_pulses", last_seen, 1);
        check("adr_left", exp_adr_q.size(), 0);
        check("word_left", exp_data_q.size(), 0);
        if (mode == 0) check("full_rate", last_rd - first_rd, n - 1);
    endtask

    initial begin
        int k, v0, r0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst = 1'b1; start = 1'b0; outReady = 1'b0; baseAdr = '0; len = '0;
`ifdef RAM_READER_ABORT_EN
        abort = 1'b0;
`endif
        clear_model();
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_burst(10'h010, 4, 0, 1'b0);
        run_burst(10'h3FE, 4, 0, 1'b0);
        run_burst(DEPTH_LOG'($urandom), 8, 1, 1'b1);

        // Zero-length request: no reads, no data, done exactly one cycle later.
        clear_model();
        v0 = valid_total; r0 = rd_total;
        @(posedge clk); #1;
        start = 1'b1; len = '0; baseAdr = 10'h055;
        @(negedge clk);
        check("len0_done_early", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("len0_done_cnt", done_cnt, 1);
        check("len0_no_valid", valid_total - v0, 0);
        check("len0_no_read", rd_total - r0, 0);

        // Reset in the middle of a 16-word burst.
        clear_model();
        expect_burst(10'h123, 16);
        @(posedge clk); #1;
        baseAdr = 10'h123; len = 11'd16; start = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (popped < 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("rst_reach_3", popped >= 3, 1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        v0 = valid_total; r0 = rd_total;
        repeat (20) @(posedge clk);
        check("post_rst_no_valid", valid_total - v0, 0);
        check("post_rst_no_read", rd_total - r0, 0);
        run_burst(10'h020, 6, 0, 1'b0);

        for (int i = 0; i < 6; i++) run_burst(DEPTH_LOG'($urandom), $urandom_range(1, 40), 2, 1'b0);
        run_burst(DEPTH_LOG'($urandom), DEPTH, 2, 1'b0);

`ifdef RAM_READER_ABORT_EN
        clear_model();
        expect_burst(10'h100, 16);
        @(posedge clk); #1;
        baseAdr = 10'h100; len = 11'd16; start = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (popped < 2 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_done", done, 1);
        check("abort_no_read", rdEn, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_off", outValid, 0);
        check("abort_busy_off", busy, 0);
        v0 = valid_total; r0 = rd_total;
        repeat (10) @(negedge clk);
        check("abort_no_valid", valid_total - v0, 0);
        check("abort_no_read_after", rd_total - r0, 0);
        check("abort_no_last", last_seen, 0);
        check("abort_done_cnt", done_cnt, 1);
        clear_model();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, RAM word and stream data width.
REQ-002 SHALL have parameter DEPTH_LOG, default 10, RAM address width.
REQ-003 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a burst.
REQ-006 SHALL have port baseAdr, input, DEPTH_LOG, the first word address, sampled when start is accepted.
REQ-007 SHALL have port len, input, DEPTH_LOG+1, the word count, sampled when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while a burst is active.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when a burst completes.
REQ-010 SHALL have port rdEn, output, 1, the RAM read enable.
REQ-011 SHALL have port rdAdr, output, DEPTH_LOG, the RAM read address.
REQ-012 SHALL have port rdDat, input, WIDTH, the RAM registered read data.
REQ-013 SHALL have port outValid, output, 1, stream valid.
REQ-014 SHALL have port outData, output, WIDTH, stream data.
REQ-015 SHALL have port outLast, output, 1, high with the final word of a burst.
REQ-016 SHALL have port outReady, input, 1, stream ready from the sink.

Function
REQ-017 SHALL treat the RAM as 1-cycle read latency: rdDat is valid in the cycle after rdEn=1, and the RAM holds rdDat when rdEn=0.
REQ-018 SHALL implement the FSM states IDLE, READ and DRAIN.
REQ-019 SHALL accept start only in IDLE and ignore start in the other states.
REQ-020 SHALL, on an accepted start with len>0, go IDLE->READ and assert busy from the next cycle.
REQ-021 SHALL, on an accepted start with len=0, stay in IDLE, issue no reads and pulse done on the next cycle.
REQ-022 SHALL issue addresses baseAdr, baseAdr+1, ... modulo 2^DEPTH_LOG, so 2^DEPTH_LOG-1 wraps to 0.
REQ-023 SHALL hold a 2-entry output buffer and count in-flight reads (0 or 1).
REQ-024 SHALL assert rdEn in READ only when remaining>0 and (2 - occupancy - inflight + pop) > 0, where pop = outValid&outReady in that cycle.
REQ-025 SHALL sustain one word per cycle while outReady stays high.
REQ-026 SHALL never drop or duplicate a word under any outReady pattern.
REQ-027 SHALL keep outData and outLast stable while outValid=1 and outReady=0.
REQ-028 SHALL go READ->DRAIN when the last read is issued.
REQ-029 SHALL go DRAIN->IDLE on the cycle the outLast word is popped, pulsing done in that same cycle.
REQ-030 SHALL deassert busy in the cycle after done.
REQ-031 SHALL set len=2^DEPTH_LOG to read the whole RAM once, ending at baseAdr-1.

Reset
REQ-032 SHALL, on rst, immediately force the state to IDLE, busy=0, done=0, rdEn=0, rdAdr=0, outValid=0, outData=0, outLast=0, and clear the buffer and in-flight count.
REQ-033 SHALL abandon any burst when rst asserts mid-burst and emit no further words after reset releases.

Configuration
REQ-034 SHALL, when macro RAM_READER_ABORT_EN is defined, add an input port abort (1 bit).
REQ-035 SHALL, with RAM_READER_ABORT_EN defined and abort=1 in READ or DRAIN, stop issuing reads, discard the buffer and any in-flight word, go to IDLE next cycle and pulse done without asserting outLast.
REQ-036 SHALL, without RAM_READER_ABORT_EN defined, have no abort port and run every burst to completion.

Verification
REQ-037 SHALL verify: baseAdr=0x010, len=4, outReady=1 -> rdAdr 0x010..0x013 on consecutive cycles, 4 words in order, outLast on the 4th, one done pulse.
REQ-038 SHALL verify: baseAdr=0x3FE, len=4, DEPTH_LOG=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-039 SHALL verify: len=8 with outReady toggling 1,0,0,1 repeating -> exactly 8 words in order, data stable during stalls, at most 1 in-flight read plus 2 buffered.
REQ-040 SHALL verify: len=0 start -> no rdEn, no outValid, done one cycle later.
REQ-041 SHALL verify: rst asserted after the 3rd word of a len=16 burst -> all outputs 0 immediately, no words after release, next start behaves normally.
REQ-042 SHALL verify, with RAM_READER_ABORT_EN defined: abort during a len=16 burst -> reads stop, outValid=0 next cycle, done pulses, outLast never asserts.
